pipelined_cla_adder: RTL
========================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised pipelined carry-lookahead adder/subtractor for datapath use.
//  WIDTH-bit operands split into STAGES slices; each slice is built from
//  BLOCK-bit lookahead groups and closed by one register stage.
//  Valid/ready handshake on input and output. Full-throughput, stallable.
//  Signed overflow flag added.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of STAGES*BLOCK
//  BLOCK   4   bits per lookahead group (group G/P, ripple between groups)
//  STAGES  2   pipeline register stages = latency in cycles (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1: A-B, 0: A+B+cin
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out; in sub mode 1 = no borrow (A>=B unsigned)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid bits 0; sum, cout, ovf 0;
//    out_valid 0. in_ready is 1 while rst_n high and pipeline not full.
//  - Effective operands: B' = sub ? ~b : b; C0 = sub ? 1 : cin.
//  - SW = WIDTH/STAGES. Stage k (0..STAGES-1) computes bits [k*SW +: SW]
//    from the carry registered by stage k-1 (stage 0 uses C0), registers
//    its partial sum, its carry-out, and the not-yet-added upper operand
//    bits plus the sign bits of A and B' needed for ovf.
//  - Final stage: cout = carry out of bit WIDTH-1;
//    ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]).
//  - Latency: beat accepted in cycle n appears with out_valid in cycle n+STAGES
//    when no stall occurs. Throughput 1 beat/cycle.
//  - Handshake: transfer on valid&ready at the rising edge. Stage k loads when
//    !vld[k] | rdy[k+1]; rdy[STAGES] = out_ready; in_ready = rdy[0] (combinational
//    from out_ready, no skid buffer). Stalled stage holds all data stable.
//  - out_valid, sum, cout, ovf are held unchanged while out_valid & !out_ready.
//  - in_valid & !in_ready: inputs ignored; the source holds them.
//  - Bubbles: a stage with vld=0 drops its data contents; outputs for vld=0 are
//    don't-care, and the bench checks them only when out_valid=1.
//  - Wrap-around: unsigned overflow wraps modulo 2^WIDTH and sets cout;
//    there is no saturation.
//  - Reset mid-operation: all in-flight beats are discarded; nothing is
//    emitted after rst_n deasserts until new inputs are accepted.
//  - STAGES=1: a single register stage; the behaviour matches a registered
//    32-bit CLA.
// TESTING
//  1 a=32'hFFFF_FFFF,b=1,cin=0,sub=0 -> after 2 cycles sum=0,cout=1,ovf=0
//  2 a=32'h7FFF_FFFF,b=1,sub=0 -> sum=32'h8000_0000,cout=0,ovf=1;
//    a=32'h8000_0000,b=1,sub=1 -> sum=32'h7FFF_FFFF,cout=1,ovf=1
//  3 a=5,b=7,sub=1 -> sum=32'hFFFF_FFFE,cout=0,ovf=0; a=7,b=5,sub=1 -> sum=2,cout=1
//  4 back-to-back 1000 random beats, out_ready=1 -> one result/cycle,
//    in order, all match reference model; out_valid first at cycle 2
//  5 out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 beats
//    buffered; outputs stable; no loss/duplication after release
//  6 rst_n low for 1 cycle with 2 beats in flight -> out_valid=0, outputs 0,
//    no stale beat emitted; repeat tests 1-4 with WIDTH=64,BLOCK=8,STAGES=4

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH-bit operands are split into STAGES slices of SW bits; each slice is
// summed by BLOCK-bit lookahead groups and closed by one register stage.
// The valid/ready handshake is full-throughput and stallable, with no skid buffer.

// Combinational slice: lookahead inside each BLOCK-bit group, group carry ripples.
module cla_slice #(
    parameter int W     = 16,
    parameter int BLOCK = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int NG = W / BLOCK;

    logic [W-1:0] g, p, c;

    assign g = a & b;
    assign p = a ^ b;
    assign s = p ^ c;

    // Bit carries come from the group prefix G/P and the group carry-in;
    // the group G/P then produces the next group's carry-in.
    always_comb begin
        logic cr, gg, gp;
        c  = '0;
        cr = ci;
        for (int n = 0; n < NG; n++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                c[n*BLOCK+i] = gg | (gp & cr);
                gg = g[n*BLOCK+i] | (p[n*BLOCK+i] & gg);
                gp = gp & p[n*BLOCK+i];
            end
            cr = gg | (gp & cr);
        end
        co = cr;
    end
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0]  beff;
    logic              c0;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;   // [0] is the input beat, [k+1] is stage k
    logic [STAGES-1:0] rdy;        // stage k may load this cycle

    // Subtraction is A + ~B + 1; cin only matters in add mode.
    assign beff = sub ? ~b : b;
    assign c0   = sub | cin;

    assign vld_pipe  = {vld_q, in_valid};
    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES];

    // Stage k loads when it is empty or everything downstream can move;
    // unrolled so the ready chain has no self-referencing vector.
    always_comb begin
        logic r;
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            r = out_ready;
            for (int j = k + 1; j <= STAGES; j++)
                r = r | ~vld_pipe[j];
            rdy[k] = r;
        end
    end

    // Valid shift register, each bit advancing only when its stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else
            for (int k = 1; k <= STAGES; k++)
                if (rdy[k-1])
                    vld_q[k] <= vld_pipe[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = WIDTH - k*SW;   // operand bits not yet added
        localparam int LO = k*SW;           // sum bits already produced

        logic [RW-1:0]    ai, bi;
        logic             ci, sai, sbi;
        logic [SW-1:0]    ps;
        logic             pc;
        logic [LO+SW-1:0] sn;

        if (k == 0) begin : g_in
            assign ai  = a;
            assign bi  = beff;
            assign ci  = c0;
            assign sai = a[WIDTH-1];
            assign sbi = beff[WIDTH-1];
            assign sn  = ps;
        end else begin : g_in
            assign ai  = g_stg[k-1].g_mid.a_r;
            assign bi  = g_stg[k-1].g_mid.b_r;
            assign ci  = g_stg[k-1].g_mid.c_r;
            assign sai = g_stg[k-1].g_mid.sa_r;
            assign sbi = g_stg[k-1].g_mid.sb_r;
            assign sn  = {ps, g_stg[k-1].g_mid.s_r};
        end

        cla_slice #(.W(SW), .BLOCK(BLOCK)) u_cla (
            .a  (ai[SW-1:0]),
            .b  (bi[SW-1:0]),
            .ci (ci),
            .s  (ps),
            .co (pc)
        );

        if (k < STAGES - 1) begin : g_mid
            logic [RW-SW-1:0] a_r, b_r;
            logic [LO+SW-1:0] s_r;
            logic             c_r, sa_r, sb_r;

            // Carry partial sum, slice carry, remaining operands and sign bits forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r  <= '0;
                    b_r  <= '0;
                    s_r  <= '0;
                    c_r  <= 1'b0;
                    sa_r <= 1'b0;
                    sb_r <= 1'b0;
                end else if (rdy[k]) begin
                    a_r  <= ai[RW-1:SW];
                    b_r  <= bi[RW-1:SW];
                    s_r  <= sn;
                    c_r  <= pc;
                    sa_r <= sai;
                    sb_r <= sbi;
                end
            end
        end else begin : g_last
            // Output register: held while the consumer stalls a valid result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum  <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (rdy[k]) begin
                    sum  <= sn;
                    cout <= pc;
                    ovf  <= (sai == sbi) & (sn[WIDTH-1] != sai);
                end
            end
        end
    end
endmodule
